// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, FSM encoding and muldiv op helpers.
package mips_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = 6;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_PREP = 3'd1;
    localparam logic [ST_W-1:0] ST_ITER = 3'd2;
    localparam logic [ST_W-1:0] ST_FIX  = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE = 3'd4;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } op_t;

    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    // Only meaningful when is_muldiv() holds: bit 1 selects divide, bit 0 unsigned.
    function automatic op_t decode_op(input logic [5:0] funct);
        op_t op;
        op.is_div    = funct[1];
        op.is_signed = ~funct[0];
        return op;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath with sign correction.
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            load_signed_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            op_div_i,
    input  logic [ST_W-1:0] phase_i,
    output logic [XLEN-1:0] hi_res_o,
    output logic [XLEN-1:0] lo_res_o
);

    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   mag_q, mag_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh, trial;
    logic [2*XLEN-1:0] div_next;
    logic              sign_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    assign abs_a = neg_a_q ? -a_q : a_q;
    assign abs_b = neg_b_q ? -b_q : b_q;

    // Multiply: acc = {partial, multiplier}; add on LSB then shift right.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, keep trial if non-negative.
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, mag_q};
    assign div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        if (load_i) begin
            a_d     = rs_i;
            b_d     = rt_i;
            neg_a_d = load_signed_i & rs_i[XLEN-1];
            neg_b_d = load_signed_i & rt_i[XLEN-1];
        end else begin
            case (phase_i)
                ST_PREP: begin
                    if (op_div_i) begin
                        mag_d = abs_b;
                        acc_d = {{XLEN{1'b0}}, abs_a};
                    end else begin
                        mag_d = abs_a;
                        acc_d = {{XLEN{1'b0}}, abs_b};
                    end
                end
                ST_ITER: acc_d = op_div_i ? div_next : mul_next;
                default: ;
            endcase
        end
    end

    assign sign_diff = neg_a_q ^ neg_b_q;
    assign prod      = sign_diff ? -acc_q : acc_q;
    assign quot      = acc_q[XLEN-1:0];
    assign rem       = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        hi_res_o = prod[2*XLEN-1:XLEN];
        lo_res_o = prod[XLEN-1:0];
        if (op_div_i) begin
            if (b_q == '0) begin
                // Divide by zero: report raw dividend, not the sign-fixed magnitude.
                hi_res_o = a_q;
                lo_res_o = '1;
            end else begin
                hi_res_o = neg_a_q ? -rem : rem;
                lo_res_o = sign_diff ? -quot : quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mag_q   <= '0;
            acc_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV controller owning HI/LO; sequences the datapath and stalls IF/ID.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [5:0]      funct_i,
    input  logic [XLEN-1:0] rs_val_i,
    input  logic [XLEN-1:0] rt_val_i,
    input  logic            mf_req_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            stall_o
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(XLEN - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    op_t              start_op;
    logic             accept;
    logic [XLEN-1:0]  hi_res, lo_res;

    assign start_op = decode_op(funct_i);
    assign accept   = start_i & is_muldiv(funct_i) & ~kill_i &
                      ((state_q == ST_IDLE) | (state_q == ST_DONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d  = ST_PREP;
                    op_div_d = start_op.is_div;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                cnt_d   = '0;
                state_d = kill_i ? ST_IDLE : ST_ITER;
            end
            ST_ITER: begin
                if (kill_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (kill_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    hi_d    = hi_res;
                    lo_d    = lo_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_PREP) | (state_d == ST_ITER) | (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (accept),
        .load_signed_i (start_op.is_signed),
        .rs_i          (rs_val_i),
        .rt_i          (rt_val_i),
        .op_div_i      (op_div_q),
        .phase_i       (state_q),
        .hi_res_o      (hi_res),
        .lo_res_o      (lo_res)
    );

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    // Not stalled in DONE, so an MFHI/MFLO there reads the freshly written value.
    assign stall_o = busy_q & (mf_req_i | start_i);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: vector table + random ops through a scoreboard, plus corner sequences.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val;
    logic        mf_req, kill;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    muldiv_sequencer #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .funct_i  (funct),
        .rs_val_i (rs_val),
        .rt_val_i (rt_val),
        .mf_req_i (mf_req),
        .kill_i   (kill),
        .hi_o     (hi),
        .lo_o     (lo),
        .busy_o   (busy),
        .done_o   (done),
        .stall_o  (stall)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop on done; an entry past its due cycle without done is a miss.
    exp_t mon_e;
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
            end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "_done"}, 32'(done), 32'd1);
        end
    end

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        int     q, r;
        case (f)
            6'h18: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            6'h19: return {32'h0, a} * {32'h0, b};
            6'h1A: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; leaves the caller one negedge later with start low.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                         input string name, output int c0);
        exp_t e;
        c0     = cyc;
        start  = 1'b1;
        funct  = f;
        rs_val = a;
        rt_val = b;
        if (push) begin
            e.hi   = ehi;
            e.lo   = elo;
            e.due  = c0 + 35;
            e.name = name;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    vec_t        vecs[7];
    int          c0;
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    logic [63:0] m;

    initial begin
        vecs[0] = '{6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1] = '{6'h18, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg"};
        vecs[2] = '{6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"};
        vecs[3] = '{6'h1B, 32'd100, 32'h0, 32'd100, 32'hFFFF_FFFF, "divu_zero"};
        vecs[4] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf"};
        vecs[5] = '{6'h1B, 32'd50, 32'd7, 32'd1, 32'd7, "divu_50_7"};
        vecs[6] = '{6'h1A, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_zero"};

        rst_n = 1'b0; start = 1'b0; funct = 6'h0; rs_val = '0; rt_val = '0;
        mf_req = 1'b0; kill = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max with busy window checks
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h1, "seq1", c0);
        check("seq1_busy_prep", 32'(busy), 32'd1);
        while (cyc < c0 + 34) @(negedge clk);
        check("seq1_busy_fix", 32'(busy), 32'd1);
        check("seq1_done_fix", 32'(done), 32'd0);
        @(negedge clk);
        check("seq1_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("seq1_done_pulse", 32'(done), 32'd0);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].funct, vecs[i].rs, vecs[i].rt, 1'b1, vecs[i].hi, vecs[i].lo,
                  vecs[i].name, c0);
            wait_drain(vecs[i].name);
        end

        // mf_req stall and a start held across busy, accepted in DONE
        issue(6'h19, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, "op1", c0);
        while (cyc < c0 + 5) @(negedge clk);
        mf_req = 1'b1;
        @(negedge clk);
        check("stall_mf", 32'(stall), 32'd1);
        while (cyc < c0 + 10) @(negedge clk);
        start = 1'b1; funct = 6'h1B; rs_val = 32'd50; rt_val = 32'd7;
        sb_q.push_back('{32'd1, 32'd7, c0 + 70, "held_divu"});
        @(negedge clk);
        check("stall_start", 32'(stall), 32'd1);
        check("held_not_restarted_busy", 32'(busy), 32'd1);
        while (cyc < c0 + 34) @(negedge clk);
        check("stall_fix", 32'(stall), 32'd1);
        @(negedge clk);
        check("stall_done_cycle", 32'(stall), 32'd0);
        check("mfhi_in_done_lo", lo, 32'd15);
        @(negedge clk);
        start = 1'b0; mf_req = 1'b0;
        check("held_accepted_busy", 32'(busy), 32'd1);
        wait_drain("held_divu");

        // kill mid-ITER
        issue(6'h19, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, "pre_kill", c0);
        wait_drain("pre_kill");
        issue(6'h1B, 32'd50, 32'd7, 1'b0, 32'h0, 32'h0, "killed", c0);
        while (cyc < c0 + 12) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_done", 32'(done), 32'd0);
        check("kill_hi", hi, 32'h0);
        check("kill_lo", lo, 32'd15);
        repeat (40) @(negedge clk);
        check("kill_hi_later", hi, 32'h0);
        check("kill_lo_later", lo, 32'd15);
        start = 1'b1; kill = 1'b1; funct = 6'h1B; rs_val = 32'd9; rt_val = 32'd2;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_dropped", 32'(busy), 32'd0);
        issue(6'h1B, 32'd50, 32'd7, 1'b1, 32'd1, 32'd7, "after_kill", c0);
        wait_drain("after_kill");

        // reset mid-ITER, then an invalid funct
        issue(6'h19, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0, "reset_victim", c0);
        while (cyc < c0 + 15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(6'h20, 32'd1, 32'd1, 1'b0, 32'h0, 32'h0, "bad_funct", c0);
        check("bad_funct_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("bad_funct_lo", lo, 32'h0);

        for (int i = 0; i < 12; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            m = model(rf, ra, rb);
            issue(rf, ra, rb, 1'b1, m[63:32], m[31:0], $sformatf("rand%0d_f%0h", i, rf), c0);
            wait_drain("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
